// File: rtl/dbus_pkg.sv
// Shared types and defaults for the dbus copy engine: FSM states, default widths,
// bus-idle drive values and a state-classification helper.
package dbus_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 16;

    // Value driven on bus_we whenever the engine does not own a bus cycle;
    // address and write data idle at all-zeros so the bus can OR-mux initiators.
    localparam logic BUS_WE_IDLE = 1'b0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } dma_state_e;

    // States in which the engine holds (or is waiting for) the bus.
    function automatic logic is_active(input dma_state_e s);
        return (s == REQ) || (s == RD) || (s == CAP) || (s == WR);
    endfunction

endpackage

// File: rtl/dbus_dma.sv
// Copies len words src->dst over dbus, 3 cycles/word after grant, +1 cycle DONE.
// Waits in REQ with the bus idle until granted; start is ignored unless IDLE.
module dbus_dma
    import dbus_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic [AW-1:0] bus_addr,
    output logic          bus_we,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata
);

    dma_state_e    state, state_n;
    logic [AW-1:0] src_ptr, src_n;
    logic [AW-1:0] dst_ptr, dst_n;
    logic [AW-1:0] rem, rem_n;
    logic [DW-1:0] data_q, data_n;

    logic [AW-1:0] addr_n;
    logic          we_n;
    logic [DW-1:0] wdata_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            rem     <= '0;
            data_q  <= '0;
        end else begin
            state   <= state_n;
            src_ptr <= src_n;
            dst_ptr <= dst_n;
            rem     <= rem_n;
            data_q  <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        src_n   = src_ptr;
        dst_n   = dst_ptr;
        rem_n   = rem;
        data_n  = data_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        src_n   = src;
                        dst_n   = dst;
                        rem_n   = len;
                        state_n = REQ;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) state_n = RD;
            end
            RD: begin
                state_n = CAP;
            end
            CAP: begin
                data_n  = bus_rdata;
                state_n = WR;
            end
            WR: begin
                src_n   = src_ptr + AW'(1);
                dst_n   = dst_ptr + AW'(1);
                rem_n   = rem - AW'(1);
                state_n = (rem == AW'(1)) ? DONE : RD;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bus outputs are computed from the next state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        addr_n  = '0;
        we_n    = BUS_WE_IDLE;
        wdata_n = '0;
        case (state_n)
            RD, CAP: begin
                addr_n = src_n;
            end
            WR: begin
                addr_n  = dst_n;
                we_n    = 1'b1;
                wdata_n = data_n;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            bus_req   <= 1'b0;
            bus_addr  <= '0;
            bus_we    <= BUS_WE_IDLE;
            bus_wdata <= '0;
        end else begin
            busy      <= is_active(state_n);
            done      <= (state_n == DONE);
            bus_req   <= is_active(state_n);
            bus_addr  <= addr_n;
            bus_we    <= we_n;
            bus_wdata <= wdata_n;
        end
    end

endmodule

// File: tb/tb_dbus_dma.sv
// Directed bench for dbus_dma with a behavioural single-port dbus RAM (registered read).
module tb_dbus_dma;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src, dst, len;
    logic          busy, done, bus_req, bus_gnt, bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;

    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_dat;
    logic [DW-1:0] mem [0:65535];

    int err_cnt = 0;
    int chk_cnt = 0;
    int we_cnt = 0, req_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    dbus_dma #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always @(posedge clk) begin
        if (bus_we) mem[bus_addr] <= bus_wdata;
        else if (pl_we) mem[pl_addr] <= pl_dat;
        bus_rdata <= mem[bus_addr];
    end

    always @(negedge clk) begin
        if (bus_we)  we_cnt   <= we_cnt + 1;
        if (bus_req) req_cnt  <= req_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a;
        pl_dat  = d;
        pl_we   = 1'b1;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Returns at the negedge of the cycle after the start edge.
    task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, we0, req0, done0, bad, wr, k;
        rst = 1'b1; start = 1'b0; bus_gnt = 1'b0; pl_we = 1'b0;
        pl_addr = '0; pl_dat = '0; src = '0; dst = '0; len = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic 3-word copy with grant already high
        bus_gnt = 1'b1;
        poke(16'h0000, 16'h0030); poke(16'h0001, 16'h0031); poke(16'h0002, 16'h0032);
        poke(16'h0010, 16'h0000); poke(16'h0011, 16'h0000); poke(16'h0012, 16'h0000);
        #1; we0 = we_cnt; done0 = done_cnt;
        start_copy(16'h0000, 16'h0010, 16'd3);
        chk("t1_busy", busy, 1);
        chk("t1_req", bus_req, 1);
        wait_done(40, n);
        chk("t1_latency", n, 10);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_busy_end", busy, 0);
        repeat (2) @(negedge clk); #1;
        chk("t1_we_cycles", we_cnt - we0, 3);
        chk("t1_done_cnt", done_cnt - done0, 1);
        chk("t1_m10", mem[16'h0010], 16'h0030);
        chk("t1_m11", mem[16'h0011], 16'h0031);
        chk("t1_m12", mem[16'h0012], 16'h0032);

        // 2: zero length
        we0 = we_cnt; req0 = req_cnt; done0 = done_cnt;
        start_copy(16'h0005, 16'h0006, 16'd0);
        chk("t2_done", done, 1);
        @(negedge clk);
        chk("t2_done_clr", done, 0);
        repeat (2) @(negedge clk); #1;
        chk("t2_req_cnt", req_cnt - req0, 0);
        chk("t2_we_cnt", we_cnt - we0, 0);
        chk("t2_done_cnt", done_cnt - done0, 1);

        // 3: grant withheld for 5 cycles
        bus_gnt = 1'b0;
        poke(16'h0040, 16'h00A0); poke(16'h0041, 16'h00A1);
        poke(16'h0050, 16'h0000); poke(16'h0051, 16'h0000);
        #1; we0 = we_cnt;
        start_copy(16'h0040, 16'h0050, 16'd2);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 16'h0000) bad++;
            @(negedge clk);
        end
        #1;
        chk("t3_wait_idle", bad, 0);
        chk("t3_no_we", we_cnt - we0, 0);
        bus_gnt = 1'b1;
        wait_done(40, n);
        chk("t3_latency", n, 7);
        chk("t3_m50", mem[16'h0050], 16'h00A0);
        chk("t3_m51", mem[16'h0051], 16'h00A1);

        // 4: source pointer wraps
        poke(16'hFFFF, 16'hBEEF);
        poke(16'h0020, 16'h0000); poke(16'h0021, 16'h0000);
        start_copy(16'hFFFF, 16'h0020, 16'd2);
        @(negedge clk);
        chk("t4_rd_addr0", bus_addr, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("t4_rd_addr1", bus_addr, 16'h0000);
        wait_done(40, n);
        chk("t4_latency", n, 3);
        chk("t4_m20", mem[16'h0020], 16'hBEEF);
        chk("t4_m21", mem[16'h0021], 16'h0030);

        // 5: async reset during the second write
        poke(16'h0060, 16'h00C0); poke(16'h0061, 16'h00C1);
        poke(16'h0062, 16'h00C2); poke(16'h0063, 16'h00C3);
        poke(16'h0070, 16'h0000); poke(16'h0071, 16'h0000);
        poke(16'h0072, 16'h0000); poke(16'h0073, 16'h0000);
        #1; done0 = done_cnt;
        start_copy(16'h0060, 16'h0070, 16'd4);
        wr = 0; k = 0;
        while (wr < 2 && k < 30) begin
            @(negedge clk);
            k++;
            if (bus_we) wr++;
        end
        chk("t5_second_wr", wr, 2);
        rst = 1'b1;
        #1;
        chk("t5_we_abort", bus_we, 0);
        chk("t5_busy_abort", busy, 0);
        chk("t5_req_abort", bus_req, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk); #1;
        chk("t5_no_done", done_cnt - done0, 0);
        chk("t5_m70", mem[16'h0070], 16'h00C0);
        chk("t5_m72", mem[16'h0072], 16'h0000);
        chk("t5_m73", mem[16'h0073], 16'h0000);

        // 6: start while busy is ignored
        poke(16'h0080, 16'h00D0); poke(16'h0081, 16'h00D1);
        poke(16'h0090, 16'h0000); poke(16'h0091, 16'h0000); poke(16'h00A0, 16'h0000);
        #1; done0 = done_cnt;
        start_copy(16'h0080, 16'h0090, 16'd2);
        repeat (2) @(negedge clk);
        src = 16'h0060; dst = 16'h00A0; len = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, n);
        chk("t6_latency", n, 4);
        chk("t6_m90", mem[16'h0090], 16'h00D0);
        chk("t6_m91", mem[16'h0091], 16'h00D1);
        repeat (6) @(negedge clk); #1;
        chk("t6_mA0", mem[16'h00A0], 16'h0000);
        chk("t6_done_cnt", done_cnt - done0, 1);
        chk("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
